// File: rtl/char2bcd.sv
// char2bcd -- character-stream to sign + packed BCD parser.
//
// Accepts one display/ASCII character per ch_valid/ch_ready handshake and
// assembles an optionally signed decimal number of up to DIGITS digits.
// CR terminates the entry, and the result is held on sign/bcd/err until
// out_valid/out_ready completes. ESC aborts the current entry. Malformed
// entries are completed anyway and flagged with err.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   reset      synchronous active-high reset
//   ch_valid   character present on ch
//   ch         character code (8 bits)
//   ch_ready   parser accepts ch this cycle (low while a result is held)
//   out_valid  result held on sign/bcd/err
//   out_ready  consumer takes the result
//   sign       1 = negative (never set for a zero result)
//   bcd        packed BCD, digit 0 in bits [3:0], right-justified
//   err        entry was malformed
module char2bcd #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ch_valid,
  input  logic [7:0]            ch,
  output logic                  ch_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  err
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_BLANK = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_ESC   = 8'h1B;

  typedef enum logic [1:0] {
    S_IDLE,
    S_NUM,
    S_OUT
  } state_t;

  state_t          state_q, state_d;
  logic            neg_q,   neg_d;
  logic [BW-1:0]   acc_q,   acc_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic            errf_q,  errf_d;
  logic            sign_q,  sign_d;
  logic [BW-1:0]   bcd_q,   bcd_d;
  logic            err_q,   err_d;

  logic            take;
  logic            is_digit;
  logic [3:0]      digit;

  assign ch_ready  = (state_q != S_OUT);
  assign out_valid = (state_q == S_OUT);
  assign sign      = sign_q;
  assign bcd       = bcd_q;
  assign err       = err_q;

  assign take     = ch_valid && ch_ready;
  assign is_digit = (ch >= 8'h30) && (ch <= 8'h39);
  // For '0'..'9' the low nibble of the code is the digit value.
  assign digit    = ch[3:0];

  always_comb begin
    state_d = state_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    errf_d  = errf_q;
    sign_d  = sign_q;
    bcd_d   = bcd_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (take) begin
          if (is_digit) begin
            acc_d   = BW'(digit);
            cnt_d   = CW'(1);
            state_d = S_NUM;
          end else if (ch == CH_MINUS) begin
            neg_d   = 1'b1;
            state_d = S_NUM;
          end else if (ch == CH_BLANK) begin
            // leading blanks are skipped
          end else if (ch == CH_CR) begin
            sign_d  = 1'b0;
            bcd_d   = '0;
            err_d   = errf_q;
            state_d = S_OUT;
          end else if (ch == CH_ESC) begin
            neg_d  = 1'b0;
            acc_d  = '0;
            cnt_d  = '0;
            errf_d = 1'b0;
          end else begin
            // An invalid first character still starts an entry so that
            // the error is reported when CR arrives.
            errf_d  = 1'b1;
            state_d = S_NUM;
          end
        end
      end

      S_NUM: begin
        if (take) begin
          if (is_digit) begin
            if (cnt_q < CW'(DIGITS)) begin
              acc_d = (acc_q << 4) | BW'(digit);
              cnt_d = cnt_q + CW'(1);
            end else begin
              errf_d = 1'b1;
            end
          end else if (ch == CH_CR) begin
            // Zero is never reported as negative.
            sign_d  = neg_q && (acc_q != '0);
            bcd_d   = acc_q;
            err_d   = errf_q;
            state_d = S_OUT;
          end else if (ch == CH_ESC) begin
            neg_d   = 1'b0;
            acc_d   = '0;
            cnt_d   = '0;
            errf_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            errf_d = 1'b1;
          end
        end
      end

      S_OUT: begin
        if (out_ready) begin
          neg_d   = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          errf_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      errf_q  <= 1'b0;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      errf_q  <= errf_d;
      sign_q  <= sign_d;
      bcd_q   <= bcd_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_char2bcd.sv
module tb_char2bcd;

  logic        clk;
  logic        reset;
  logic        ch_valid;
  logic [7:0]  ch;
  logic        ch_ready;
  logic        out_valid;
  logic        out_ready;
  logic        sign;
  logic [15:0] bcd;
  logic        err;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  char2bcd #(.DIGITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .ch_valid  (ch_valid),
    .ch        (ch),
    .ch_ready  (ch_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign      (sign),
    .bcd       (bcd),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one character for exactly one cycle (parser must be ready).
  task automatic send(input logic [7:0] c);
    ch_valid = 1'b1;
    ch       = c;
    step();
    ch_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic s, input logic [15:0] b, input logic e);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_sign"},  {31'd0, sign},      {31'd0, s});
    check({tag, "_bcd"},   {16'd0, bcd},       {16'd0, b});
    check({tag, "_err"},   {31'd0, err},       {31'd0, e});
  endtask

  initial begin
    reset     = 1'b1;
    ch_valid  = 1'b0;
    ch        = 8'h00;
    out_ready = 1'b1;
    step();
    step();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sign",  {31'd0, sign},      32'd0);
    check("rst_bcd",   {16'd0, bcd},       32'd0);
    check("rst_err",   {31'd0, err},       32'd0);
    reset = 1'b0;
    step();
    check("rst_ready", {31'd0, ch_ready},  32'd1);

    // -123 back to back, out_ready tied high: one-cycle result pulse
    send(8'h2D); send(8'h31); send(8'h32); send(8'h33); send(8'h0D);
    check_result("neg123", 1'b1, 16'h0123, 1'b0);
    check("neg123_rdy", {31'd0, ch_ready}, 32'd0);
    step();
    check("neg123_pulse", {31'd0, out_valid}, 32'd0);
    check("neg123_hold",  {16'd0, bcd},       32'h0123);

    // Overflow keeps first four digits and flags error
    send(8'h39); send(8'h38); send(8'h37); send(8'h36); send(8'h35); send(8'h0D);
    check_result("ovf", 1'b0, 16'h9876, 1'b1);
    step();
    // Blanks skipped, error cleared by previous acceptance
    send(8'h20); send(8'h20); send(8'h34); send(8'h0D);
    check_result("blank4", 1'b0, 16'h0004, 1'b0);
    step();

    // Negative zero and lone CR
    send(8'h2D); send(8'h30); send(8'h0D);
    check_result("negzero", 1'b0, 16'h0000, 1'b0);
    step();
    send(8'h0D);
    check_result("lonecr", 1'b0, 16'h0000, 1'b0);
    step();

    // Back-pressure: result held while a new character waits
    out_ready = 1'b0;
    send(8'h34); send(8'h32); send(8'h0D);
    check_result("bp42", 1'b0, 16'h0042, 1'b0);
    ch_valid = 1'b1;
    ch       = 8'h37;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_rdy",   {31'd0, ch_ready},  32'd0);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_bcd",   {16'd0, bcd},       32'h0042);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_rel_valid", {31'd0, out_valid}, 32'd0);
    check("bp_rel_rdy",   {31'd0, ch_ready},  32'd1);
    step();               // '7' consumed here
    ch_valid  = 1'b0;
    out_ready = 1'b1;
    send(8'h0D);
    check_result("bp7", 1'b0, 16'h0007, 1'b0);
    step();

    // ESC abort, invalid character, misplaced minus
    send(8'h31); send(8'h32); send(8'h1B); send(8'h33); send(8'h0D);
    check_result("esc", 1'b0, 16'h0003, 1'b0);
    step();
    send(8'h31); send(8'h41); send(8'h32); send(8'h0D);
    check_result("inval", 1'b0, 16'h0012, 1'b1);
    step();
    send(8'h31); send(8'h2D); send(8'h0D);
    check_result("minus", 1'b0, 16'h0001, 1'b1);
    step();

    // Leading zeros count toward the digit limit
    send(8'h30); send(8'h30); send(8'h30); send(8'h31); send(8'h32); send(8'h0D);
    check_result("lead0", 1'b0, 16'h0001, 1'b1);
    step();

    // Invalid first character in IDLE
    send(8'h41); send(8'h35); send(8'h0D);
    check_result("inval_first", 1'b0, 16'h0005, 1'b1);
    step();

    // Reset coinciding with CR discards the entry
    send(8'h35); send(8'h35);
    ch_valid = 1'b1;
    ch       = 8'h0D;
    reset    = 1'b1;
    step();
    reset    = 1'b0;
    ch_valid = 1'b0;
    check("rstcr_valid", {31'd0, out_valid}, 32'd0);
    check("rstcr_bcd",   {16'd0, bcd},       32'd0);
    check("rstcr_rdy",   {31'd0, ch_ready},  32'd1);
    step();
    check("rstcr_valid2", {31'd0, out_valid}, 32'd0);
    send(8'h37); send(8'h0D);
    check_result("post_rst", 1'b0, 16'h0007, 1'b0);
    step();

    // Reset during OUT drops the held result
    out_ready = 1'b0;
    send(8'h2D); send(8'h39); send(8'h0D);
    check_result("out_rst_pre", 1'b1, 16'h0009, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("out_rst_valid", {31'd0, out_valid}, 32'd0);
    check("out_rst_sign",  {31'd0, sign},      32'd0);
    check("out_rst_bcd",   {16'd0, bcd},       32'd0);
    out_ready = 1'b1;
    step();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
